// File: rtl/axi_host_mem_pkg.sv
// Shared response codes, FSM state types and address helpers for the
// host-memory responder.
package axi_host_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } rd_state_t;

    // Word index inside the RAM: drop the byte offset, keep DEPTH_LOG2 bits.
    function automatic logic [31:0] word_index(input logic [63:0] addr,
                                               input int ofs,
                                               input int depth_log2);
        logic [63:0] sh;
        sh = addr >> ofs;
        return sh[31:0] & ((32'd1 << depth_log2) - 32'd1);
    endfunction

    // Error class of a burst, decided once when its address is accepted.
    function automatic logic [1:0] addr_resp(input logic [63:0] addr,
                                             input logic [2:0]  size,
                                             input int          ofs,
                                             input int          depth_log2);
        if ((addr >> (ofs + depth_log2)) != 64'd0) return RESP_DECERR;
        if (int'(size) != ofs)                      return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port block RAM: byte-enabled write port, registered read port.
// A same-word read and write in one cycle returns the old contents.
module bram_sdp #(
    parameter int WIDTH  = 512,
    parameter int ADDR_W = 10
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [ADDR_W-1:0]    i_waddr,
    input  logic [WIDTH/8-1:0]   i_wbe,
    input  logic [WIDTH-1:0]     i_wdata,
    input  logic                 i_re,
    input  logic [ADDR_W-1:0]    i_raddr,
    output logic [WIDTH-1:0]     o_rdata
);

    logic [WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [WIDTH-1:0] r_rdata;

    // Byte-lane write, only lanes with their enable set are updated.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < WIDTH/8; b++) begin
                if (i_wbe[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    // Registered read; output holds while no read is issued.
    always_ff @(posedge i_clk) begin
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_host_mem_responder.sv
// AXI4 INCR-burst memory responder backed by a block RAM, standing in for
// host memory. Read and write engines run independently.
module axi_host_mem_responder
    import axi_host_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 48,
    parameter int ID_WIDTH   = 1,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic [7:0]              i_awlen,
    input  logic [2:0]              i_awsize,
    input  logic [ID_WIDTH-1:0]     i_awid,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wlast,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    output logic [1:0]              o_bresp,
    output logic [ID_WIDTH-1:0]     o_bid,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic [7:0]              i_arlen,
    input  logic [2:0]              i_arsize,
    input  logic [ID_WIDTH-1:0]     i_arid,
    output logic                    o_rvalid,
    input  logic                    i_rready,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic [ID_WIDTH-1:0]     o_rid,
    output logic                    o_rlast
);

    localparam int OFS = $clog2(DATA_WIDTH/8);

    // ---------------- write engine ----------------
    wr_state_t               r_wstate, w_wstate_nxt;
    logic [DEPTH_LOG2-1:0]   r_widx;
    logic [7:0]              r_wlen, r_wcnt;
    logic [ID_WIDTH-1:0]     r_wid;
    logic [1:0]              r_werr;
    logic                    w_aw_hs, w_w_hs, w_wfinal, w_we;

    assign w_aw_hs  = i_awvalid && o_awready;
    assign w_w_hs   = i_wvalid && o_wready;
    assign w_wfinal = (r_wcnt == r_wlen);
    // Bytes land only while the burst is still clean; earlier beats stay.
    assign w_we     = w_w_hs && (r_werr == RESP_OKAY);

    // Write FSM state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_wstate <= W_IDLE;
        else            r_wstate <= w_wstate_nxt;
    end

    // Write FSM next state and handshake outputs.
    always_comb begin
        w_wstate_nxt = r_wstate;
        o_awready    = 1'b0;
        o_wready     = 1'b0;
        o_bvalid     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                o_awready = 1'b1;
                if (i_awvalid) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                o_wready = 1'b1;
                if (i_wvalid && w_wfinal) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                o_bvalid = 1'b1;
                if (i_bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Write burst context: latched on AW, advanced per beat, wlast audited.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_widx <= '0;
            r_wlen <= '0;
            r_wcnt <= '0;
            r_wid  <= '0;
            r_werr <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_widx <= DEPTH_LOG2'(word_index(64'(i_awaddr), OFS, DEPTH_LOG2));
                r_wlen <= i_awlen;
                r_wcnt <= 8'd0;
                r_wid  <= i_awid;
                r_werr <= addr_resp(64'(i_awaddr), i_awsize, OFS, DEPTH_LOG2);
            end
            if (w_w_hs) begin
                r_widx <= r_widx + 1'b1;
                r_wcnt <= r_wcnt + 8'd1;
                if ((i_wlast != w_wfinal) && (r_werr != RESP_DECERR))
                    r_werr <= RESP_SLVERR;
            end
        end
    end

    assign o_bresp = r_werr;
    assign o_bid   = r_wid;

    // ---------------- read engine ----------------
    rd_state_t               r_rstate, w_rstate_nxt;
    logic [DEPTH_LOG2-1:0]   r_ridx;
    logic [7:0]              r_rlen, r_ricnt;
    logic                    r_rdone;
    logic [ID_WIDTH-1:0]     r_rid;
    logic [1:0]              r_rerr;
    logic                    r_pend, r_pend_last;
    logic                    r_ovalid, r_olast;
    logic [DATA_WIDTH-1:0]   r_odata;
    logic [DATA_WIDTH-1:0]   w_ram_q;
    logic                    w_ar_hs, w_adv, w_issue;

    assign w_ar_hs = i_arvalid && o_arready;
    // The output slot frees up this cycle if it is empty or being drained.
    assign w_adv   = !r_ovalid || i_rready;
    assign w_issue = (r_rstate == R_BURST) && w_adv && !r_rdone;

    // Read FSM state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_rstate <= R_IDLE;
        else            r_rstate <= w_rstate_nxt;
    end

    // Read FSM next state; leave the burst on the rlast handshake.
    always_comb begin
        w_rstate_nxt = r_rstate;
        o_arready    = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                o_arready = 1'b1;
                if (i_arvalid) w_rstate_nxt = R_BURST;
            end
            R_BURST: begin
                if (r_ovalid && i_rready && r_olast) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Read pipeline: RAM read stage (r_pend) feeding a one-deep output slot.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ridx      <= '0;
            r_rlen      <= '0;
            r_ricnt     <= '0;
            r_rdone     <= 1'b0;
            r_rid       <= '0;
            r_rerr      <= RESP_OKAY;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_ovalid    <= 1'b0;
            r_olast     <= 1'b0;
            r_odata     <= '0;
        end else begin
            if (w_ar_hs) begin
                r_ridx   <= DEPTH_LOG2'(word_index(64'(i_araddr), OFS, DEPTH_LOG2));
                r_rlen   <= i_arlen;
                r_ricnt  <= 8'd0;
                r_rdone  <= 1'b0;
                r_rid    <= i_arid;
                r_rerr   <= addr_resp(64'(i_araddr), i_arsize, OFS, DEPTH_LOG2);
                r_pend   <= 1'b0;
                r_ovalid <= 1'b0;
            end
            if (w_issue) begin
                r_ridx  <= r_ridx + 1'b1;
                r_ricnt <= r_ricnt + 8'd1;
                if (r_ricnt == r_rlen) r_rdone <= 1'b1;
            end
            if ((r_rstate == R_BURST) && w_adv) begin
                r_pend      <= w_issue;
                r_pend_last <= (r_ricnt == r_rlen);
                r_ovalid    <= r_pend;
                r_olast     <= r_pend && r_pend_last;
                if (r_pend)
                    r_odata <= (r_rerr == RESP_DECERR) ? '0 : w_ram_q;
            end
        end
    end

    assign o_rvalid = r_ovalid;
    assign o_rdata  = r_odata;
    assign o_rresp  = r_rerr;
    assign o_rid    = r_rid;
    assign o_rlast  = r_olast;

    bram_sdp #(
        .WIDTH  (DATA_WIDTH),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (r_widx),
        .i_wbe   (i_wstrb),
        .i_wdata (i_wdata),
        .i_re    (w_issue),
        .i_raddr (r_ridx),
        .o_rdata (w_ram_q)
    );

endmodule

// File: tb/tb_axi_host_mem_responder.sv
// Randomised self-checking bench for axi_host_mem_responder against a
// word-array model of memory and the address/size/wlast error rules.
module tb_axi_host_mem_responder;

    localparam int DW = 512;
    localparam int AW = 48;
    localparam int SW = DW/8;
    localparam int NW = 1024;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          awvalid = 0, awready;
    logic [AW-1:0] awaddr = '0;
    logic [7:0]    awlen = '0;
    logic [2:0]    awsize = '0;
    logic          awid = 0;
    logic          wvalid = 0, wready;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic          wlast = 0;
    logic          bvalid, bready = 0;
    logic [1:0]    bresp;
    logic          bid;
    logic          arvalid = 0, arready;
    logic [AW-1:0] araddr = '0;
    logic [7:0]    arlen = '0;
    logic [2:0]    arsize = '0;
    logic          arid = 0;
    logic          rvalid, rready = 0;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rid;
    logic          rlast;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] mdl [NW];
    logic [DW-1:0] wq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_host_mem_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(1), .DEPTH_LOG2(10)
    ) dut (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_awvalid(awvalid), .o_awready(awready), .i_awaddr(awaddr),
        .i_awlen(awlen), .i_awsize(awsize), .i_awid(awid),
        .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata),
        .i_wstrb(wstrb), .i_wlast(wlast),
        .o_bvalid(bvalid), .i_bready(bready), .o_bresp(bresp), .o_bid(bid),
        .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr),
        .i_arlen(arlen), .i_arsize(arsize), .i_arid(arid),
        .o_rvalid(rvalid), .i_rready(rready), .o_rdata(rdata),
        .o_rresp(rresp), .o_rid(rid), .o_rlast(rlast)
    );

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] v;
        for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // 64 KiB of backing store at 64-byte words: anything at or above 64 KiB
    // is undecodable; a beat size other than 64 bytes is a slave error.
    function automatic logic [1:0] exp_err(input logic [AW-1:0] addr, input logic [2:0] size);
        if (addr >= 48'h10000) return 2'b11;
        if (size != 3'd6)      return 2'b10;
        return 2'b00;
    endfunction

    function automatic int idx_of(input logic [AW-1:0] addr);
        return int'((addr / 64) % NW);
    endfunction

    task automatic do_write(input logic [AW-1:0] addr, input int len, input logic [2:0] size,
                            input logic id, input int last_beat, input logic [SW-1:0] strb,
                            input bit rnd_strb);
        logic [1:0]    err;
        logic [DW-1:0] d;
        logic [SW-1:0] st;
        int idx, t;
        err = exp_err(addr, size);
        idx = idx_of(addr);
        @(negedge clk);
        awvalid = 1; awaddr = addr; awlen = 8'(len); awsize = size; awid = id;
        t = 0;
        while (!awready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin
            total++; bad++; $display("FAIL aw_timeout addr=%h", addr);
            awvalid = 0; return;
        end
        @(negedge clk);
        awvalid = 0;
        for (int b = 0; b <= len; b++) begin
            d  = (wq.size() > 0) ? wq.pop_front() : rnd_word();
            st = rnd_strb ? {$urandom, $urandom} : strb;
            wvalid = 1; wdata = d; wstrb = st; wlast = (b == last_beat);
            t = 0;
            while (!wready && t < 200) begin @(negedge clk); t++; end
            if (t >= 200) begin
                total++; bad++; $display("FAIL w_timeout beat=%0d", b);
                wvalid = 0; return;
            end
            if (err == 2'b00)
                for (int k = 0; k < SW; k++) if (st[k]) mdl[idx][k*8 +: 8] = d[k*8 +: 8];
            if (((b == last_beat) != (b == len)) && err != 2'b11) err = 2'b10;
            idx = (idx + 1) % NW;
            @(negedge clk);
        end
        wvalid = 0; wlast = 0; bready = 1;
        t = 0;
        while (!bvalid && t < 200) begin @(negedge clk); t++; end
        total++;
        if (t >= 200) begin
            bad++; $display("FAIL b_timeout addr=%h", addr);
        end else if (bresp !== err || bid !== id) begin
            bad++;
            $display("FAIL bresp addr=%h: got resp=%0d id=%0d, want resp=%0d id=%0d",
                     addr, bresp, bid, err, id);
        end
        @(negedge clk);
        bready = 0;
    endtask

    // rmode: 0 rready held high, 1 pattern 1,0,0,1, 2 random.
    // abort_at >= 0 returns once that many beats have been taken.
    task automatic do_read(input logic [AW-1:0] addr, input int len, input logic [2:0] size,
                           input logic id, input int rmode, input int abort_at, input bit chk_lat);
        logic [1:0]    err;
        logic [DW-1:0] ex;
        int idx, t, hs, beat, p;
        bit rr, held, lat_done;
        err = exp_err(addr, size);
        idx = idx_of(addr);
        @(negedge clk);
        arvalid = 1; araddr = addr; arlen = 8'(len); arsize = size; arid = id;
        t = 0;
        while (!arready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin
            total++; bad++; $display("FAIL ar_timeout addr=%h", addr);
            arvalid = 0; return;
        end
        hs = cyc + 1;
        @(negedge clk);
        arvalid = 0;
        beat = 0; p = 0; t = 0; held = 0; lat_done = 0;
        while (beat <= len && t < 4000) begin
            if (beat == abort_at) begin rready = 0; return; end
            case (rmode)
                0:       rr = 1;
                1:       rr = (p % 4 == 0) || (p % 4 == 3);
                default: rr = 1'($urandom_range(0, 1));
            endcase
            rready = rr; p++;
            if (held) begin
                total++;
                if (rvalid !== 1'b1) begin
                    bad++; $display("FAIL rvalid_dropped beat=%0d got=%b want=1", beat, rvalid);
                end
            end
            if (rvalid) begin
                if (chk_lat && !lat_done) begin
                    total++; lat_done = 1;
                    if (cyc - hs != 2) begin
                        bad++; $display("FAIL first_rvalid_latency got=%0d want=2", cyc - hs);
                    end
                end
                ex = (err == 2'b11) ? '0 : mdl[(idx + beat) % NW];
                total++;
                if (rdata !== ex || rresp !== err || rid !== id || rlast !== (beat == len)) begin
                    bad++;
                    $display("FAIL rbeat %0d addr=%h: got data=%h resp=%0d id=%0d last=%0d want data=%h resp=%0d id=%0d last=%0d",
                             beat, addr, rdata, rresp, rid, rlast, ex, err, id, (beat == len));
                end
                held = !rr;
                if (rr) beat++;
            end else begin
                held = 0;
            end
            @(negedge clk);
            t++;
        end
        rready = 0;
        total++;
        if (t >= 4000) begin
            bad++; $display("FAIL r_timeout addr=%h beats=%0d want=%0d", addr, beat, len + 1);
        end else if (rvalid !== 1'b0 || arready !== 1'b1) begin
            bad++; $display("FAIL read_end rvalid=%b arready=%b want 0/1", rvalid, arready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000) begin
            bad++; $display("FAIL reset_hs got=%b want=110000",
                            {awready, arready, wready, bvalid, rvalid, rlast});
        end
        total++;
        if (bresp !== 0 || rresp !== 0 || bid !== 0 || rid !== 0 || rdata !== '0) begin
            bad++; $display("FAIL reset_payload bresp=%0d rresp=%0d bid=%0d rid=%0d rdata=%h want 0",
                            bresp, rresp, bid, rid, rdata);
        end
        reset_n = 1;
        @(negedge clk);
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) do_write(48'(k * 256 * 64), 255, 3'd6, 1'(k), 255, '1, 0);
    endtask

    task automatic test_basic();
        for (int k = 0; k < 4; k++) wq.push_back(DW'(8'hA0 + k));
        do_write(48'h40, 3, 3'd6, 1'b1, 3, '1, 0);
        do_read(48'h40, 3, 3'd6, 1'b1, 0, -1, 1);
    endtask

    task automatic test_stall();
        do_write(48'h1000, 15, 3'd6, 1'b0, 15, '1, 0);
        do_read(48'h1000, 15, 3'd6, 1'b0, 1, -1, 1);
    endtask

    task automatic test_strobe();
        wq.push_back('1);
        do_write(48'd5 * 64, 0, 3'd6, 1'b0, 0, '1, 0);
        do_write(48'd5 * 64, 0, 3'd6, 1'b1, 0, 64'h0F, 0);
        do_read(48'd5 * 64, 0, 3'd6, 1'b1, 0, -1, 0);
    endtask

    task automatic test_decerr();
        do_write(48'h10000, 1, 3'd6, 1'b1, 1, '1, 0);
        do_read(48'h0, 1, 3'd6, 1'b0, 0, -1, 0);
        do_read(48'h10000, 1, 3'd6, 1'b1, 2, -1, 0);
    endtask

    task automatic test_slverr();
        do_write(48'h200, 1, 3'd6, 1'b0, 0, '1, 0);
        do_read(48'h200, 1, 3'd6, 1'b0, 0, -1, 0);
        do_read(48'h300, 3, 3'd3, 1'b1, 2, -1, 0);
        do_write(48'h380, 2, 3'd6, 1'b1, -1, '1, 0);
    endtask

    task automatic test_reset_midburst();
        do_read(48'h400, 7, 3'd6, 1'b1, 0, 2, 0);
        @(negedge clk);
        reset_n = 0;
        #1;
        total++;
        if (rvalid !== 1'b0 || arready !== 1'b1 || awready !== 1'b1) begin
            bad++; $display("FAIL reset_mid rvalid=%b arready=%b awready=%b want 0/1/1",
                            rvalid, arready, awready);
        end
        @(negedge clk);
        reset_n = 1;
        do_read(48'h400, 7, 3'd6, 1'b0, 2, -1, 1);
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a;
        logic [2:0]    sz;
        int len, lb;
        do_write(48'd1022 * 64, 3, 3'd6, 1'b0, 3, '1, 1);
        do_read(48'd1022 * 64, 3, 3'd6, 1'b0, 2, -1, 0);
        for (int i = 0; i < 24; i++) begin
            a  = 48'($urandom_range(0, 16'hFFFF));
            if ($urandom_range(0, 7) == 0) a = a | (48'd1 << $urandom_range(16, 47));
            sz  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd6;
            len = $urandom_range(0, 12);
            lb  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : len;
            do_write(a, len, sz, 1'($urandom), lb, '1, 1);
            a  = 48'($urandom_range(0, 16'hFFFF));
            if ($urandom_range(0, 7) == 0) a = a | (48'd1 << $urandom_range(16, 47));
            sz = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd6;
            do_read(a, $urandom_range(0, 12), sz, 1'($urandom), 2, -1, 1);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_stall();
        test_strobe();
        test_decerr();
        test_slverr();
        test_reset_midburst();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
